// File: rtl/miter_cmp_scheduler.sv
// Time-multiplexed gold/gate comparator for an equivalence miter: scans N snapshotted
// lanes one per cycle, records the first mismatch, counts mismatches and gives a verdict.
module miter_cmp_scheduler #(
    parameter int unsigned N            = 4,
    parameter int unsigned W            = 8,
    parameter int unsigned STOP_ON_FAIL = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [N*W-1:0]                        gold_in,
    input  logic [N*W-1:0]                        gate_in,
    input  logic [N*W-1:0]                        dcare_in,
    input  logic [N-1:0]                          lane_en,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  pass,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  fail_lane,
    output logic [W-1:0]                          fail_bits,
    output logic [$clog2(N+1)-1:0]                fail_count
);

    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [N*W-1:0]  gold_q, gold_d, gate_q, gate_d, dcare_q, dcare_d;
    logic [N-1:0]    en_q, en_d;
    logic            pass_q, pass_d;
    logic [LW-1:0]   fail_lane_q, fail_lane_d;
    logic [W-1:0]    fail_bits_q, fail_bits_d;
    logic [CW-1:0]   fail_count_q, fail_count_d;
    logic [W-1:0]    diff;
    logic            mismatch;
    logic            last_lane;

    always_comb begin
        diff      = (gold_q[idx_q*W +: W] ^ gate_q[idx_q*W +: W]) & ~dcare_q[idx_q*W +: W];
        mismatch  = en_q[idx_q] & (|diff);
        last_lane = (idx_q == LW'(N - 1));
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gold_d       = gold_q;
        gate_d       = gate_q;
        dcare_d      = dcare_q;
        en_d         = en_q;
        pass_d       = pass_q;
        fail_lane_d  = fail_lane_q;
        fail_bits_d  = fail_bits_q;
        fail_count_d = fail_count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gold_d       = gold_in;
                    gate_d       = gate_in;
                    dcare_d      = dcare_in;
                    en_d         = lane_en;
                    pass_d       = 1'b0;
                    fail_lane_d  = '0;
                    fail_bits_d  = '0;
                    fail_count_d = '0;
                    idx_d        = '0;
                    state_d      = StScan;
                end
            end
            StScan: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + CW'(1);
                    // Only the first mismatch of a scan is recorded.
                    if (fail_count_q == '0) begin
                        fail_lane_d = idx_q;
                        fail_bits_d = diff;
                    end
                end
                if (last_lane || ((STOP_ON_FAIL != 0) && mismatch)) begin
                    state_d = StDone;
                    pass_d  = (fail_count_d == '0);
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            gold_q       <= '0;
            gate_q       <= '0;
            dcare_q      <= '0;
            en_q         <= '0;
            pass_q       <= 1'b0;
            fail_lane_q  <= '0;
            fail_bits_q  <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gold_q       <= gold_d;
            gate_q       <= gate_d;
            dcare_q      <= dcare_d;
            en_q         <= en_d;
            pass_q       <= pass_d;
            fail_lane_q  <= fail_lane_d;
            fail_bits_q  <= fail_bits_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign busy       = (state_q == StScan);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign fail_lane  = fail_lane_q;
    assign fail_bits  = fail_bits_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_miter_cmp_scheduler.sv
// Directed bench for miter_cmp_scheduler: one full-scan instance and one stop-on-fail
// instance share the same lane inputs.
module tb_miter_cmp_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] gold, gate, dcare;
    logic [3:0]  en;

    logic       busy_m, done_m, pass_m;
    logic [1:0] lane_m;
    logic [7:0] bits_m;
    logic [2:0] cnt_m;
    logic       busy_s, done_s, pass_s;
    logic [1:0] lane_s;
    logic [7:0] bits_s;
    logic [2:0] cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    miter_cmp_scheduler #(.N(4), .W(8), .STOP_ON_FAIL(0)) dut_m (
        .clk(clk), .rst(rst), .start(start), .gold_in(gold), .gate_in(gate),
        .dcare_in(dcare), .lane_en(en), .busy(busy_m), .done(done_m), .pass(pass_m),
        .fail_lane(lane_m), .fail_bits(bits_m), .fail_count(cnt_m)
    );

    miter_cmp_scheduler #(.N(4), .W(8), .STOP_ON_FAIL(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .gold_in(gold), .gate_in(gate),
        .dcare_in(dcare), .lane_en(en), .busy(busy_s), .done(done_s), .pass(pass_s),
        .fail_lane(lane_s), .fail_bits(bits_s), .fail_count(cnt_s)
    );

    task automatic set_clean();
        gold  = {4{8'hA5}};
        gate  = {4{8'hA5}};
        dcare = '0;
        en    = 4'hF;
    endtask

    // Pulses start across edge t; returns at the falling edge inside cycle t+1.
    task automatic kick();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; set_clean();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL reset_done got %0h want 0", done_m); end
        checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL reset_pass got %0h want 0", pass_m); end
        checks++; if (lane_m !== 2'd0) begin errors++; $display("FAIL reset_lane got %0h want 0", lane_m); end
        checks++; if (bits_m !== 8'h00) begin errors++; $display("FAIL reset_bits got %0h want 0", bits_m); end
        checks++; if (cnt_m !== 3'd0) begin errors++; $display("FAIL reset_count got %0h want 0", cnt_m); end
        checks++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            errors++; $display("FAIL reset_stop busy/done got %0h/%0h want 0/0", busy_s, done_s);
        end
    endtask

    task automatic test_clean();
        set_clean();
        kick();
        for (int c = 1; c <= 5; c++) begin
            checks++; if (busy_m !== (c <= 4)) begin
                errors++; $display("FAIL clean_busy c%0d got %0h want %0h", c, busy_m, (c <= 4));
            end
            checks++; if (done_m !== (c == 5)) begin
                errors++; $display("FAIL clean_done c%0d got %0h want %0h", c, done_m, (c == 5));
            end
            checks++; if (done_s !== (c == 5)) begin
                errors++; $display("FAIL clean_stop_done c%0d got %0h want %0h", c, done_s, (c == 5));
            end
            if (c < 5) @(negedge clk);
        end
        checks++; if (pass_m !== 1'b1) begin errors++; $display("FAIL clean_pass got %0h want 1", pass_m); end
        checks++; if (cnt_m !== 3'd0) begin errors++; $display("FAIL clean_count got %0h want 0", cnt_m); end
        @(negedge clk);
        checks++; if (done_m !== 1'b0 || pass_m !== 1'b1) begin
            errors++; $display("FAIL clean_hold done/pass got %0h/%0h want 0/1", done_m, pass_m);
        end
    endtask

    task automatic test_multi();
        set_clean();
        gate[15:8]  = 8'hA4;
        gate[31:24] = 8'h25;
        kick();
        for (int c = 1; c <= 5; c++) begin
            checks++; if (done_m !== (c == 5)) begin
                errors++; $display("FAIL multi_done c%0d got %0h want %0h", c, done_m, (c == 5));
            end
            checks++; if (done_s !== (c == 3)) begin
                errors++; $display("FAIL stop_done c%0d got %0h want %0h", c, done_s, (c == 3));
            end
            checks++; if (busy_s !== (c <= 2)) begin
                errors++; $display("FAIL stop_busy c%0d got %0h want %0h", c, busy_s, (c <= 2));
            end
            if (c < 5) @(negedge clk);
        end
        checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL multi_pass got %0h want 0", pass_m); end
        checks++; if (cnt_m !== 3'd2) begin errors++; $display("FAIL multi_count got %0h want 2", cnt_m); end
        checks++; if (lane_m !== 2'd1) begin errors++; $display("FAIL multi_lane got %0h want 1", lane_m); end
        checks++; if (bits_m !== 8'h01) begin errors++; $display("FAIL multi_bits got %0h want 01", bits_m); end
        checks++; if (cnt_s !== 3'd1) begin errors++; $display("FAIL stop_count got %0h want 1", cnt_s); end
        checks++; if (lane_s !== 2'd1) begin errors++; $display("FAIL stop_lane got %0h want 1", lane_s); end
        checks++; if (pass_s !== 1'b0) begin errors++; $display("FAIL stop_pass got %0h want 0", pass_s); end
        @(negedge clk);
    endtask

    task automatic test_dcare();
        set_clean();
        gold[23:16]  = 8'hF0;
        gate[23:16]  = 8'h0F;
        dcare[23:16] = 8'hFF;
        kick();
        repeat (4) @(negedge clk);
        checks++; if (done_m !== 1'b1 || pass_m !== 1'b1) begin
            errors++; $display("FAIL dcare_full done/pass got %0h/%0h want 1/1", done_m, pass_m);
        end
        @(negedge clk);
        dcare[23:16] = 8'hFE;
        kick();
        repeat (4) @(negedge clk);
        checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL dcare_part_pass got %0h want 0", pass_m); end
        checks++; if (lane_m !== 2'd2) begin errors++; $display("FAIL dcare_part_lane got %0h want 2", lane_m); end
        checks++; if (bits_m !== 8'h01) begin errors++; $display("FAIL dcare_part_bits got %0h want 01", bits_m); end
        checks++; if (cnt_m !== 3'd1) begin errors++; $display("FAIL dcare_part_count got %0h want 1", cnt_m); end
        @(negedge clk);
    endtask

    task automatic test_lane_en();
        set_clean();
        gate[7:0] = 8'h00;
        en        = 4'hE;
        kick();
        repeat (4) @(negedge clk);
        checks++; if (pass_m !== 1'b1 || cnt_m !== 3'd0) begin
            errors++; $display("FAIL lane_en pass/count got %0h/%0h want 1/0", pass_m, cnt_m);
        end
        checks++; if (done_s !== 1'b1) begin errors++; $display("FAIL lane_en_stop_done got %0h want 1", done_s); end
        @(negedge clk);
        gate = 32'h0;
        en   = 4'h0;
        kick();
        repeat (4) @(negedge clk);
        checks++; if (done_m !== 1'b1 || pass_m !== 1'b1 || cnt_m !== 3'd0) begin
            errors++; $display("FAIL all_disabled done/pass/count got %0h/%0h/%0h want 1/1/0", done_m, pass_m, cnt_m);
        end
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        set_clean();
        kick();
        @(negedge clk);
        start       = 1'b1;
        gold[31:24] = 8'h00;
        for (int c = 2; c <= 5; c++) begin
            checks++; if (done_m !== (c == 5) || busy_m !== (c < 5)) begin
                errors++; $display("FAIL snap_timing c%0d done/busy got %0h/%0h", c, done_m, busy_m);
            end
            if (c < 5) @(negedge clk);
        end
        checks++; if (pass_m !== 1'b1 || cnt_m !== 3'd0) begin
            errors++; $display("FAIL snap_result pass/count got %0h/%0h want 1/0", pass_m, cnt_m);
        end
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin
            errors++; $display("FAIL snap_no_restart busy/done got %0h/%0h want 0/0", busy_m, done_m);
        end
        set_clean();
    endtask

    task automatic test_reset_mid();
        set_clean();
        gate[7:0] = 8'h5A;
        kick();
        @(negedge clk);
        checks++; if (cnt_m !== 3'd1 || bits_m !== 8'hFF) begin
            errors++; $display("FAIL mid_pre count/bits got %0h/%0h want 1/ff", cnt_m, bits_m);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({busy_m, done_m, pass_m, lane_m, bits_m, cnt_m} !== 15'd0) begin
            errors++; $display("FAIL mid_reset got b%0h d%0h p%0h l%0h f%0h c%0h want all 0",
                               busy_m, done_m, pass_m, lane_m, bits_m, cnt_m);
        end
        for (int c = 0; c < 4; c++) begin
            checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL mid_no_done c%0d got %0h want 0", c, done_m); end
            @(negedge clk);
        end
        set_clean();
        kick();
        repeat (4) @(negedge clk);
        checks++; if (done_m !== 1'b1 || pass_m !== 1'b1) begin
            errors++; $display("FAIL mid_restart done/pass got %0h/%0h want 1/1", done_m, pass_m);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_multi();
        test_dcare();
        test_lane_en();
        test_snapshot();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miter_cmp_scheduler.md
Name: miter_cmp_scheduler

Overview:
- Time-multiplexes one gold/gate comparison unit across N match-point lanes of an equivalence miter.
- Compares one lane per cycle, in index order, using gold-side don't-care semantics.
- Records the first mismatching lane and its differing bits, counts mismatches, and reports a pass/fail verdict.
- Sits between the miter's gold/gate instances and the assertion/reporting logic; replaces per-lane comparators when N is large.

Parameters:
- N, 4, number of lanes (match points); N >= 2.
- W, 8, bit width of each lane.
- STOP_ON_FAIL, 0, 1 = end the scan at the first mismatching lane; 0 = scan all lanes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  requests a scan; sampled only in IDLE.
- gold_in  input  N*W  gold lane values; lane i = bits [i*W +: W].
- gate_in  input  N*W  gate lane values; same packing as gold_in.
- dcare_in  input  N*W  per-bit don't-care (gold undefined); 1 = bit ignored.
- lane_en  input  N  per-lane enable; a disabled lane is never compared.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a scan completes.
- pass  output  1  verdict of the last completed scan; 1 = zero mismatches.
- fail_lane  output  max(1,$clog2(N))  index of the first mismatching lane.
- fail_bits  output  W  (gold^gate)&~dcare for the first mismatching lane.
- fail_count  output  $clog2(N+1)  number of mismatching lanes in the current or last scan.

Behaviour:
- Reset: busy=0, done=0, pass=0, fail_lane=0, fail_bits=0, fail_count=0, state=IDLE, idx=0. Reset applied mid-scan aborts the scan; done is not pulsed.
- FSM states are IDLE, SCAN and DONE.
- IDLE, start=1:
  - snapshot gold_in, gate_in, dcare_in and lane_en into internal registers;
  - clear fail_count, fail_lane, fail_bits and pass;
  - set idx=0 and go to SCAN.
  - Input changes after the snapshot have no effect on the scan in progress.
- SCAN, each cycle, for lane idx:
  - if lane_en[idx]=1, mismatch = |((gold^gate)&~dcare) over the W bits;
  - if lane_en[idx]=0, mismatch=0, but the cycle is still consumed;
  - on mismatch: fail_count += 1;
  - on the first mismatch of the scan: fail_lane=idx and fail_bits=diff; later mismatches leave both unchanged.
- SCAN exit:
  - if idx==N-1, or (STOP_ON_FAIL=1 and mismatch), go to DONE;
  - otherwise idx += 1. idx never wraps within a scan.
- DONE, one cycle:
  - done=1, pass=(fail_count==0), busy=0;
  - next state is IDLE. start in this cycle is ignored.
- Latency: start sampled at edge t; lanes are compared in cycles t+1..t+N; done is high in cycle t+N+1. With STOP_ON_FAIL=1 and the first mismatch at lane k, done is high in cycle t+k+2.
- start while busy or in DONE is ignored; it is not queued.
- pass, fail_lane, fail_bits and fail_count hold their values after done until the next accepted start.
- All lanes disabled: scan runs full length; pass=1, fail_count=0.
- Don't-care applies per bit; a bit with dcare=1 never contributes to mismatch or to fail_bits.
- fail_count saturates naturally at N; its width guarantees no overflow.

Test Plan:
- Clean scan, N=4, W=8: gold=gate=0xA5 on all lanes, lane_en=4'hF, dcare=0, start pulsed at t. Required: busy high t+1..t+4, done at t+5, pass=1, fail_count=0.
- Multiple mismatches, STOP_ON_FAIL=0: lane1 gate=0xA4, lane3 gate=0x25. Required: done at t+5, pass=0, fail_count=2, fail_lane=1, fail_bits=0x01.
- Don't-care masking: lane2 gold=0xF0, gate=0x0F, dcare=0xFF. Required: pass=1. Repeat with dcare=0xFE. Required: fail_lane=2, fail_bits=0x01.
- Lane enable and early stop:
  - lane0 mismatching with lane_en=4'hE. Required: pass=1.
  - STOP_ON_FAIL=1 with lane1 mismatching. Required: done at t+3, fail_count=1, fail_lane=1.
- Ignored start and input snapshot: pulse start again at t+2 and change gold_in at t+2. Required: no restart, done still at t+5, result reflects the inputs snapshotted at t.
- Reset mid-scan: assert rst at t+2. Required: no done pulse; next cycle all outputs 0 and busy=0; a new start then completes normally.
